// File: rtl/enemy_spawn_ctrl.sv
// Enemy spawn controller: game FSM, spawn timer, per-slot enables, lives and score.
// Optional macro ENEMY_SPAWN_LFSR_EN selects an LFSR-based spawn search start.
module enemy_spawn_ctrl #(
    parameter int unsigned PERIOD_BASE = 50000000,
    parameter int unsigned MAX_ACTIVE  = 6,
    parameter int unsigned LIVES_INIT  = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] spawn_rate,
    input  logic [9:0] touch_edge,
    input  logic [9:0] hit,
    output logic [9:0] c_en,
    output logic [9:0] des,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [3:0] active_cnt,
    output logic       game_over
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    localparam logic [31:0] PERIOD   = 32'(PERIOD_BASE);
    localparam logic [3:0]  MAX_ACT  = 4'(MAX_ACTIVE);
    localparam logic [1:0]  LIVES_LD = 2'(LIVES_INIT);

    logic [1:0]  state;
    logic [31:0] timer;
    logic [31:0] interval_m1;
    logic [9:0]  hit_v;
    logic [9:0]  edge_v;
    logic [9:0]  release_v;
    logic [9:0]  spawn_oh;
    logic [3:0]  hit_cnt;
    logic [3:0]  edge_cnt;
    logic [3:0]  search_start;
    logic [3:0]  spawn_idx;
    logic [4:0]  cand;
    logic [1:0]  lives_nxt;
    logic        tick;
    logic        found;
    logic        spawn_fire;

    assign interval_m1 = (PERIOD >> spawn_rate) - 32'd1;
    assign tick        = (timer == 32'd0);
    assign game_over   = (state == OVER);

    // Hit wins over an edge touch on the same slot; inactive slots ignore both.
    assign hit_v     = hit & c_en;
    assign edge_v    = touch_edge & c_en & ~hit;
    assign release_v = hit_v | edge_v;

    always_comb begin
        active_cnt = '0;
        hit_cnt    = '0;
        edge_cnt   = '0;
        for (int i = 0; i < 10; i++) begin
            active_cnt = active_cnt + {3'd0, c_en[i]};
            hit_cnt    = hit_cnt + {3'd0, hit_v[i]};
            edge_cnt   = edge_cnt + {3'd0, edge_v[i]};
        end
    end

    assign lives_nxt = (edge_cnt >= {2'd0, lives}) ? 2'd0 : lives - edge_cnt[1:0];

    // Walk downward so the last match found is the closest free slot at or after search_start.
    always_comb begin
        found     = 1'b0;
        spawn_idx = '0;
        cand      = '0;
        for (int k = 9; k >= 0; k--) begin
            cand = {1'b0, search_start} + 5'(k);
            if (cand >= 5'd10) begin
                cand = cand - 5'd10;
            end
            if (!c_en[cand[3:0]]) begin
                found     = 1'b1;
                spawn_idx = cand[3:0];
            end
        end
    end

    assign spawn_fire = (state == RUN) && tick && (active_cnt < MAX_ACT) && found &&
                        (lives_nxt != 2'd0);
    assign spawn_oh   = spawn_fire ? (10'd1 << spawn_idx) : 10'd0;

`ifdef ENEMY_SPAWN_LFSR_EN
    logic [9:0] lfsr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr <= 10'h2A5;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    assign search_start = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];
`else
    logic [3:0] ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (spawn_fire) begin
            ptr <= (spawn_idx == 4'd9) ? 4'd0 : spawn_idx + 4'd1;
        end
    end

    assign search_start = ptr;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            c_en  <= '0;
            des   <= '0;
            lives <= '0;
            score <= '0;
            timer <= '0;
        end else begin
            des <= '0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state <= RUN;
                        lives <= LIVES_LD;
                        score <= '0;
                        c_en  <= '0;
                        timer <= interval_m1;
                    end
                end
                RUN: begin
                    timer <= tick ? interval_m1 : timer - 32'd1;
                    score <= score + {4'd0, hit_cnt};
                    if (lives_nxt == 2'd0) begin
                        state <= OVER;
                        c_en  <= '0;
                        des   <= c_en;
                        lives <= 2'd0;
                    end else begin
                        c_en  <= (c_en & ~release_v) | spawn_oh;
                        des   <= release_v;
                        lives <= lives_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
